// File: rtl/div_request_ctrl.sv
// Request/response front end for an iterative unsigned divider.
// Handles sign fix-up and the zero-divisor and overflow fast paths, so the divider only ever sees magnitudes.
module div_request_ctrl #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [SIZE-1:0] req_a,
  input  logic [SIZE-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [SIZE-1:0] resp_data,
  output logic            div_start,
  input  logic            div_ready,
  input  logic            div_valid,
  input  logic            div_error,
  output logic [SIZE-1:0] div_dividend,
  output logic [SIZE-1:0] div_divisor,
  input  logic [SIZE-1:0] div_quotient,
  input  logic [SIZE-1:0] div_remainder
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [SIZE-1:0] ZERO_VAL = {SIZE{1'b0}};
  localparam logic [SIZE-1:0] ONE_VAL  = {{(SIZE-1){1'b0}}, 1'b1};
  localparam logic [SIZE-1:0] ONES_VAL = {SIZE{1'b1}};
  localparam logic [SIZE-1:0] MIN_VAL  = {1'b1, {(SIZE-1){1'b0}}};

  // Two's-complement negate when neg is set; the most negative value maps to itself.
  function automatic logic [SIZE-1:0] cond_neg(input logic [SIZE-1:0] v, input logic neg);
    return neg ? (~v + ONE_VAL) : v;
  endfunction

  state_t          state_r, state_s;
  logic            is_rem_r;
  logic            sign_a_r, sign_b_r;
  logic [SIZE-1:0] mag_a_r, mag_b_r;
  logic [SIZE-1:0] resp_data_r;

  logic            accept_s, signed_s, sign_a_s, sign_b_s;
  logic            zero_div_s, ovf_s, fast_s;
  logic [SIZE-1:0] fast_data_s, div_result_s;
  logic            unused_div_error_s;

  assign unused_div_error_s = div_error;

  assign accept_s   = req_valid && (state_r == IDLE);
  assign signed_s   = ~req_op[0];
  assign sign_a_s   = signed_s & req_a[SIZE-1];
  assign sign_b_s   = signed_s & req_b[SIZE-1];
  assign zero_div_s = (req_b == ZERO_VAL);
  assign ovf_s      = signed_s && (req_a == MIN_VAL) && (req_b == ONES_VAL);
  assign fast_s     = zero_div_s || ovf_s;

  // Fast-path answers: x/0 is all ones and x%0 is x; MIN/-1 is MIN with remainder 0.
  always_comb begin
    fast_data_s = ZERO_VAL;
    if (zero_div_s) begin
      fast_data_s = req_op[1] ? req_a : ONES_VAL;
    end else begin
      fast_data_s = req_op[1] ? ZERO_VAL : MIN_VAL;
    end
  end

  // Quotient sign is the XOR of operand signs; remainder follows the dividend.
  always_comb begin
    div_result_s = ZERO_VAL;
    if (is_rem_r) begin
      div_result_s = cond_neg(div_remainder, sign_a_r);
    end else begin
      div_result_s = cond_neg(div_quotient, sign_a_r ^ sign_b_r);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          state_s = fast_s ? RESP : ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (div_ready) begin
          state_s = WAIT;
        end else begin
          state_s = ISSUE;
        end
      end
      WAIT: begin
        if (div_valid) begin
          state_s = RESP;
        end else begin
          state_s = WAIT;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Operand capture on accept and result capture on fast path or divider completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      is_rem_r    <= 1'b0;
      sign_a_r    <= 1'b0;
      sign_b_r    <= 1'b0;
      mag_a_r     <= ZERO_VAL;
      mag_b_r     <= ZERO_VAL;
      resp_data_r <= ZERO_VAL;
    end else if (accept_s) begin
      is_rem_r <= req_op[1];
      sign_a_r <= sign_a_s;
      sign_b_r <= sign_b_s;
      mag_a_r  <= cond_neg(req_a, sign_a_s);
      mag_b_r  <= cond_neg(req_b, sign_b_s);
      if (fast_s) begin
        resp_data_r <= fast_data_s;
      end
    end else if ((state_r == WAIT) && div_valid) begin
      resp_data_r <= div_result_s;
    end
  end

  assign req_ready    = (state_r == IDLE);
  assign div_start    = (state_r == ISSUE);
  assign resp_valid   = (state_r == RESP);
  assign resp_data    = resp_data_r;
  assign div_dividend = mag_a_r;
  assign div_divisor  = mag_b_r;

endmodule

// File: tb/tb_div_request_ctrl.sv
// Randomized bench for div_request_ctrl: a transaction-level reference model plus a behavioural divider.
module tb_div_request_ctrl;
  localparam int SIZE = 32;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [31:0] req_a = 32'd0, req_b = 32'd0;
  logic        resp_valid, resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        div_start, div_ready = 1'b0, div_valid = 1'b0, div_error = 1'b0;
  logic [31:0] div_dividend, div_divisor;
  logic [31:0] div_quotient = 32'd0, div_remainder = 32'd0;

  always #5 clk = ~clk;

  div_request_ctrl #(.SIZE(SIZE)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .div_start(div_start), .div_ready(div_ready), .div_valid(div_valid),
    .div_error(div_error), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  int n_pass = 0, n_total = 0;

  // Reference model: one operation in flight, described by phase flags.
  bit          m_busy = 1'b0, m_issue = 1'b0, m_run = 1'b0, m_resp = 1'b0, m_zero = 1'b1;
  logic [31:0] m_data = 32'd0, m_mag_a = 32'd0, m_mag_b = 32'd0;

  // Behavioural divider (no reset).
  bit          env_busy = 1'b0;
  int          env_cnt = 0, force_lat = 0;
  logic [31:0] env_q = 32'd0, env_r = 32'd0;

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    ovf = (a == MINV) && (b == ONES);
    case (op)
      2'd0: begin
        if (b == 32'd0) return ONES;
        else if (ovf) return MINV;
        else return $signed(a) / $signed(b);
      end
      2'd1: return (b == 32'd0) ? ONES : a / b;
      2'd2: begin
        if (b == 32'd0) return a;
        else if (ovf) return 32'd0;
        else return $signed(a) % $signed(b);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] ref_mag(input logic [1:0] op, input logic [31:0] v);
    if (!op[0] && v[31]) return -v;
    return v;
  endfunction

  function automatic bit ref_fast(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == MINV && b == ONES);
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom % 7)
      0: return 32'd0;
      1: return MINV;
      2: return ONES;
      3: return $urandom % 20;
      4: return -($urandom % 20);
      5: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic compare();
    chk("req_ready", {31'd0, req_ready}, {31'd0, !m_busy});
    chk("resp_valid", {31'd0, resp_valid}, {31'd0, m_resp});
    chk("div_start", {31'd0, div_start}, {31'd0, m_issue});
    if (m_resp) chk("resp_data", resp_data, m_data);
    if (m_zero) chk("resp_data_reset", resp_data, 32'd0);
    if (m_issue) begin
      chk("div_dividend", div_dividend, m_mag_a);
      chk("div_divisor", div_divisor, m_mag_b);
    end
  endtask

  // Predict the state after the coming edge from the inputs held during this cycle.
  task automatic advance();
    if (div_start === 1'b1 && div_ready) begin
      env_busy = 1'b1;
      env_cnt  = (force_lat > 0) ? force_lat : $urandom_range(1, 4);
      env_q    = (div_divisor == 32'd0) ? ONES : div_dividend / div_divisor;
      env_r    = (div_divisor == 32'd0) ? div_dividend : div_dividend % div_divisor;
    end
    if (reset) begin
      m_busy = 1'b0; m_issue = 1'b0; m_run = 1'b0; m_resp = 1'b0; m_zero = 1'b1;
    end else if (m_resp) begin
      if (resp_ready) begin m_resp = 1'b0; m_busy = 1'b0; end
    end else if (m_run) begin
      if (div_valid) begin m_run = 1'b0; m_resp = 1'b1; end
    end else if (m_issue) begin
      if (div_ready) begin m_issue = 1'b0; m_run = 1'b1; end
    end else if (req_valid) begin
      m_busy  = 1'b1;
      m_zero  = 1'b0;
      m_data  = ref_result(req_op, req_a, req_b);
      m_mag_a = ref_mag(req_op, req_a);
      m_mag_b = ref_mag(req_op, req_b);
      if (ref_fast(req_op, req_a, req_b)) m_resp = 1'b1;
      else m_issue = 1'b1;
    end
  endtask

  task automatic do_cycle(input logic rv, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic rr, input logic rst, input logic dr);
    @(posedge clk);
    #1;
    reset = rst; req_valid = rv; req_op = op; req_a = a; req_b = b;
    resp_ready = rr; div_error = 1'($urandom % 2);
    div_ready = dr && !env_busy;
    if (env_busy) begin
      env_cnt--;
      if (env_cnt == 0) begin
        div_valid = 1'b1; div_quotient = env_q; div_remainder = env_r; env_busy = 1'b0;
      end else begin
        div_valid = 1'b0; div_quotient = $urandom; div_remainder = $urandom;
      end
    end else begin
      div_valid = ($urandom % 5 == 0); div_quotient = $urandom; div_remainder = $urandom;
    end
    @(negedge clk);
    compare();
    advance();
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input int dr_delay);
    int cyc, hc;
    logic rr;
    cyc = 0;
    while (m_busy && cyc < 50) begin do_cycle(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1); cyc++; end
    do_cycle(1'b1, op, a, b, 1'b1, 1'b0, dr_delay == 0);
    cyc = 0; hc = 0;
    while (m_busy && cyc < 100) begin
      rr = m_resp && (hc >= hold);
      if (m_resp) hc++;
      do_cycle(1'b0, 2'd0, 32'd0, 32'd0, rr, 1'b0, cyc >= dr_delay);
      cyc++;
    end
    if (m_busy) begin
      n_total++;
      $display("FAIL run_op_timeout: op %0d still busy after %0d cycles", op, cyc);
    end
  endtask

  initial begin
    int cyc;
    chk("pin DIV -7/2", ref_result(2'd0, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    chk("pin REM -7/2", ref_result(2'd2, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    chk("pin mag -7", ref_mag(2'd0, 32'hFFFF_FFF9), 32'd7);
    chk("pin DIVU max/1", ref_result(2'd1, ONES, 32'd1), ONES);
    chk("pin REMU 100/7", ref_result(2'd3, 32'd100, 32'd7), 32'd2);
    chk("pin DIV ovf", ref_result(2'd0, MINV, ONES), MINV);
    chk("pin REM ovf", ref_result(2'd2, MINV, ONES), 32'd0);
    chk("pin REM -5/0", ref_result(2'd2, 32'hFFFF_FFFB, 32'd0), 32'hFFFF_FFFB);
    chk("pin REMU 9/4", ref_result(2'd3, 32'd9, 32'd4), 32'd1);

    do_cycle(1'b1, 2'd0, 32'd5, 32'd0, 1'b1, 1'b1, 1'b1);
    do_cycle(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);

    run_op(2'd0, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 2);
    run_op(2'd1, ONES, 32'd1, 0, 0);
    run_op(2'd3, 32'd100, 32'd7, 0, 1);
    run_op(2'd0, MINV, ONES, 0, 0);
    run_op(2'd2, MINV, ONES, 0, 0);
    run_op(2'd0, 32'd5, 32'd0, 0, 0);
    run_op(2'd2, 32'hFFFF_FFFB, 32'd0, 0, 0);
    run_op(2'd1, 32'd5, 32'd0, 0, 0);
    run_op(2'd3, 32'hFFFF_FFFB, 32'd0, 0, 0);
    run_op(2'd0, 32'd77, 32'hFFFF_FFF6, 3, 0);

    // Reset while the divider is busy, then let its stale result arrive.
    force_lat = 4;
    do_cycle(1'b1, 2'd0, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 1'b1);
    cyc = 0;
    while (!m_run && cyc < 20) begin do_cycle(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1); cyc++; end
    chk("reached_wait", {31'd0, m_run}, 32'd1);
    do_cycle(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
    force_lat = 0;
    repeat (6) do_cycle(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    run_op(2'd3, 32'd9, 32'd4, 0, 3);

    repeat (3000) begin
      do_cycle(1'($urandom % 2), 2'($urandom % 4), pick(), pick(), ($urandom % 3 != 0),
               ($urandom % 60 == 0), 1'($urandom % 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
